// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE,
    HOLD
  } mult_state_e;

endpackage

// File: rtl/addsub_n.sv
// Combinational N-bit ripple add/subtract of two (N-1)-bit operands, each sign- or zero-extended.
// Subtract is performed as a + ~b + 1; o_cout is the carry out of bit N-1.
module addsub_n #(
  parameter int N = 9
) (
  input  logic [N-2:0] i_a,
  input  logic [N-2:0] i_b,
  input  logic         i_sext,
  input  logic         i_sub,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic         w_c;

  always_comb begin
    w_a    = {i_sext & i_a[N-2], i_a};
    w_b    = {i_sext & i_b[N-2], i_b} ^ {N{i_sub}};
    w_c    = i_sub;
    o_sum  = '0;
    for (int i = 0; i < N; i++) begin
      o_sum[i] = w_a[i] ^ w_b[i] ^ w_c;
      w_c      = (w_a[i] & w_b[i]) | (w_c & (w_a[i] ^ w_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: WIDTH add/shift pairs on X:A:B, Done 2*WIDTH+1 cycles after Start.
// Start is a level request honoured only in IDLE; HOLD blocks re-trigger until Start drops.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy,
  output logic                 Done,
  output logic                 X,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_e      r_state;
  mult_state_e      w_state_nxt;
  logic             r_x;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic             w_sub;
  logic             w_cout_unused;

  // Signed multiplier's top bit carries negative weight, hence the final subtract.
  assign w_sub = SIGNED && (r_cnt == LAST);

  addsub_n #(.N(WIDTH + 1)) u_addsub (
    .i_a    (r_a),
    .i_b    (r_s),
    .i_sext (SIGNED),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout_unused)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      IDLE:  if (Start) w_state_nxt = ADD;
      ADD: begin
        Busy        = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        Busy        = 1'b1;
        w_state_nxt = (r_cnt == LAST) ? DONE : ADD;
      end
      DONE: begin
        Done        = 1'b1;
        w_state_nxt = Start ? HOLD : IDLE;
      end
      HOLD:  if (!Start) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_x   <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (Start) begin
          r_x   <= 1'b0;
          r_a   <= '0;
          r_b   <= Multiplier;
          r_s   <= Multiplicand;
          r_cnt <= '0;
        end
        ADD: if (r_b[0]) {r_x, r_a} <= w_sum;
        SHIFT: begin
          r_a   <= {r_x, r_a[WIDTH-1:1]};
          r_b   <= {r_a[0], r_b[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (!SIGNED) r_x <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign X       = r_x;
  assign A       = r_a;
  assign B       = r_b;
  assign Product = {r_a, r_b};

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: three instances (8-bit signed, 8-bit unsigned, 16-bit signed),
// directed operations with expected results queued at issue and checked by per-instance monitors on Done.
module tb_seq_shift_add_multiplier;
  import mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [2:0]  start = 3'b000;
  logic [2:0]  busy, done, xo;
  logic [15:0] mcand  [3];
  logic [15:0] mplier [3];
  logic [7:0]  a0, b0, a1, b1;
  logic [15:0] a2, b2, p0, p1;
  logic [31:0] p2;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  int n_vec = 0;
  int n_err = 0;

  seq_shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b1)) dut0 (
    .Clk(clk), .Reset(rst_n), .Start(start[0]),
    .Multiplicand(mcand[0][7:0]), .Multiplier(mplier[0][7:0]),
    .Busy(busy[0]), .Done(done[0]), .X(xo[0]), .A(a0), .B(b0), .Product(p0));

  seq_shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b0)) dut1 (
    .Clk(clk), .Reset(rst_n), .Start(start[1]),
    .Multiplicand(mcand[1][7:0]), .Multiplier(mplier[1][7:0]),
    .Busy(busy[1]), .Done(done[1]), .X(xo[1]), .A(a1), .B(b1), .Product(p1));

  seq_shift_add_multiplier #(.WIDTH(16), .SIGNED(1'b1)) dut2 (
    .Clk(clk), .Reset(rst_n), .Start(start[2]),
    .Multiplicand(mcand[2]), .Multiplier(mplier[2]),
    .Busy(busy[2]), .Done(done[2]), .X(xo[2]), .A(a2), .B(b2), .Product(p2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input int d, input logic [32:0] e);
    logic [31:0] p, ab;
    case (d)
      0:       begin p = {16'b0, p0}; ab = {16'b0, a0, b0}; end
      1:       begin p = {16'b0, p1}; ab = {16'b0, a1, b1}; end
      default: begin p = p2;          ab = {a2, b2};         end
    endcase
    check($sformatf("dut%0d_product", d), 64'(p),     64'(e[31:0]));
    check($sformatf("dut%0d_a_b", d),     64'(ab),    64'(e[31:0]));
    check($sformatf("dut%0d_x", d),       64'(xo[d]), 64'(e[32]));
  endtask

  task automatic unexpected(input int d);
    n_vec++;
    n_err++;
    $display("FAIL dut%0d_done: Done asserted with no operation outstanding", d);
  endtask

  always @(negedge clk) if (done[0]) begin
    if (q0.size() == 0) unexpected(0);
    else score(0, q0.pop_front());
  end
  always @(negedge clk) if (done[1]) begin
    if (q1.size() == 0) unexpected(1);
    else score(1, q1.pop_front());
  end
  always @(negedge clk) if (done[2]) begin
    if (q2.size() == 0) unexpected(2);
    else score(2, q2.pop_front());
  end

  // Issue one operation; optionally scramble operands and re-pulse Start while busy.
  task automatic run_op(input int d, input logic [15:0] mc, input logic [15:0] mp,
                        input logic [31:0] ep, input logic ex, input bit disturb);
    int lat;
    int w;
    w = (d == 2) ? 16 : 8;
    @(negedge clk);
    mcand[d]  = mc;
    mplier[d] = mp;
    start[d]  = 1'b1;
    case (d)
      0:       q0.push_back({ex, ep});
      1:       q1.push_back({ex, ep});
      default: q2.push_back({ex, ep});
    endcase
    @(negedge clk);
    start[d] = 1'b0;
    lat = 1;
    while (!done[d] && lat < 200) begin
      if (lat == 3) check($sformatf("dut%0d_busy_mid", d), 64'(busy[d]), 64'd1);
      if (disturb && lat == 6) begin
        mcand[d]  = ~mc;
        mplier[d] = ~mp;
        start[d]  = 1'b1;
      end
      if (disturb && lat == 7) start[d] = 1'b0;
      @(negedge clk);
      lat++;
    end
    check($sformatf("dut%0d_done_latency", d), 64'(lat), 64'(2 * w + 1));
    check($sformatf("dut%0d_busy_at_done", d), 64'(busy[d]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    for (int i = 0; i < 3; i++) begin
      mcand[i]  = '0;
      mplier[i] = '0;
    end

    repeat (2) @(negedge clk);
    check("reset_busy",    64'(busy),  64'd0);
    check("reset_done",    64'(done),  64'd0);
    check("reset_x",       64'(xo),    64'd0);
    check("reset_prod0",   64'(p0),    64'd0);
    check("reset_prod1",   64'(p1),    64'd0);
    check("reset_prod2",   64'(p2),    64'd0);
    rst_n = 1'b1;

    run_op(0, 16'h0007, 16'h00FD, 32'h0000FFEB, 1'b1, 1'b0);
    run_op(0, 16'h0080, 16'h0080, 32'h00004000, 1'b0, 1'b0);
    run_op(1, 16'h00FF, 16'h00FF, 32'h0000FE01, 1'b0, 1'b0);
    run_op(1, 16'h0000, 16'h00A5, 32'h00000000, 1'b0, 1'b0);

    // Start held high for 40 cycles: one Done, then parked in HOLD.
    @(negedge clk);
    mcand[0]  = 16'h0003;
    mplier[0] = 16'h0004;
    start[0]  = 1'b1;
    q0.push_back({1'b0, 32'h0000000C});
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    check("hold_done_count", 64'(ndone), 64'd1);
    check("hold_state",      64'(dut0.r_state), 64'(HOLD));
    check("hold_busy",       64'(busy[0]), 64'd0);
    start[0] = 1'b0;
    @(negedge clk);
    check("hold_release_state", 64'(dut0.r_state), 64'(IDLE));

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    mcand[0]  = 16'h0005;
    mplier[0] = 16'h0006;
    start[0]  = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_prod", 64'(p0),      64'd0);
    check("midreset_x",    64'(xo[0]),   64'd0);
    check("midreset_busy", 64'(busy[0]), 64'd0);
    check("midreset_done", 64'(done[0]), 64'd0);
    run_op(0, 16'h0003, 16'h0005, 32'h0000000F, 1'b0, 1'b0);

    run_op(0, 16'h00FA, 16'h0009, 32'h0000FFCA, 1'b1, 1'b1);
    run_op(2, 16'h8000, 16'h0002, 32'hFFFF0000, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    check("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
# seq_shift_add_multiplier

Parametrised sequential shift-add multiplier for the lab datapath, successor to the fixed 8-bit add/subtract unit. Loads a multiplicand and multiplier, then performs WIDTH add-then-shift iterations on a (WIDTH+1)-bit X:A accumulator and a WIDTH-bit B register, producing a 2·WIDTH-bit product in X:A:B. Supports two's-complement and unsigned modes and uses a start/busy/done handshake so it can sit behind switch/button control logic or a host FSM.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..32.
- SIGNED, 1: 1 = two's-complement operands and product, 0 = unsigned.

- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-low reset; one clock, sampled on the rising edge of Clk.
- Start  in  1  level request; a multiply begins when sampled high in IDLE.
- Multiplicand  in  WIDTH  operand S, captured on start.
- Multiplier  in  WIDTH  operand, captured into B on start.
- Busy  out  1  high in ADD and SHIFT states.
- Done  out  1  high for exactly one cycle (DONE state).
- X  out  1  sign/carry extension bit of accumulator.
- A  out  WIDTH  upper product half / accumulator.
- B  out  WIDTH  lower product half / shifted multiplier.
- Product  out  2·WIDTH  {A, B}.

## Operation
- States: IDLE, ADD, SHIFT, DONE, HOLD. Reset value: IDLE; X=0, A=0, B=0, S=0, count=0; Busy=0, Done=0.
- IDLE, Start=1: A←0, X←0, B←Multiplier, S←Multiplicand, count←0; →ADD. Start=0: stay, registers held.
- ADD: if B[0]=0, {X,A} unchanged. If B[0]=1:
  - SIGNED=1, count<WIDTH-1: {X,A} ← sext(A)+sext(S), (WIDTH+1)-bit, carry out discarded.
  - SIGNED=1, count=WIDTH-1: {X,A} ← sext(A)−sext(S) (add of inverted S plus 1).
  - SIGNED=0: {X,A} ← zext(A)+zext(S); X = carry out.
  - →SHIFT.
- SHIFT: {X,A,B} shifted right one: A←{X,A[WIDTH-1:1]}, B←{A[0],B[WIDTH-1:1]}; X unchanged if SIGNED=1, X←0 if SIGNED=0; count←count+1; →DONE if count=WIDTH-1 else →ADD.
- DONE: Done=1, registers held; →HOLD if Start=1, else →IDLE.
- HOLD: registers held; →IDLE when Start=0. Prevents re-trigger while Start held.
- Start while Busy or in DONE/HOLD: ignored. Operand inputs ignored except at capture.
- Product, X, A, B stay valid from DONE until next capture.
- Reset low in any state: all registers to reset values on that edge, next state IDLE; in-flight operation discarded.
- count width: clog2(WIDTH).

## Timing
- Edge E0 captures operands (Start high in IDLE). E1..E2·WIDTH alternate ADD/SHIFT. State is DONE after E2·WIDTH; Done high during that cycle. Latency start-sample to Done: 2·WIDTH+1 cycles (17 for WIDTH=8).
- Busy high from cycle after E0 through cycle ending at E2·WIDTH.
- All outputs registered or decoded from state only (Moore); no combinational input-to-output path.
- Back-to-back: Start pulsed one cycle after Done (IDLE reached) starts a new operation; minimum spacing 2·WIDTH+2 cycles.

## Structure
- Package mult_pkg: state enum typedef (IDLE, ADD, SHIFT, DONE, HOLD), encoding left to synthesis.
- Sub-module addsub_n (parameter N = WIDTH+1): combinational N-bit add/subtract with Sub, sign/zero-extend select and carry out; ripple of full adders acceptable. Controller and shift registers live in the top module.

## Test plan
- WIDTH=8, SIGNED=1: 0x07 × 0xFD (7 × −3) → Product=0xFFEB, X=1, Done once at cycle 17.
- SIGNED=1: 0x80 × 0x80 (−128 × −128) → Product=0x4000, X=0; exercises final-subtract path.
- SIGNED=0: 0xFF × 0xFF → Product=0xFE01, X=0; 0x00 × 0xA5 → 0x0000.
- Start held high 40 cycles → exactly one Done pulse, state HOLD until Start drops, then IDLE.
- Reset low at cycle 6 of an operation → next cycle all outputs zero, Busy=0; new Start 0x03 × 0x05 → 0x000F.
- Operand inputs changed during Busy and Start re-pulsed mid-op → result unaffected; WIDTH=16, SIGNED=1: 0x8000 × 0x0002 → 0xFFFF0000.
